button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 3, number of independent button channels (mode, increment, set).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles required to accept a press or release edge; legal range 2 or more.
REQ-003 Parameter REPEAT_DELAY, default 25000000, held cycles in PRESSED before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_RATE, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_raw  input  NUM_BTN  raw asynchronous push-button levels, 1 = pressed, bounce expected.
REQ-008 btn_pulse  output  NUM_BTN  registered single-cycle press strobe per channel; drives mode_button and similar strobe inputs.
REQ-009 btn_level  output  NUM_BTN  registered debounced held level per channel.

Function
REQ-010 Each channel SHALL pass btn_raw through a two-flop synchronizer before any other logic uses it.
REQ-011 Each channel SHALL implement a four-state FSM with states IDLE, DB_PRESS, PRESSED and DB_RELEASE.
REQ-012 IDLE SHALL go to DB_PRESS when the synchronized input is 1, with the debounce counter cleared to 0.
REQ-013 In DB_PRESS the counter SHALL increment each cycle while the synchronized input is 1, and the channel SHALL return to IDLE on any 0.
REQ-014 DB_PRESS SHALL go to PRESSED at the edge where the counter equals DEBOUNCE_CYCLES-1 and the input is 1.
REQ-015 btn_pulse SHALL be 1 for exactly the first cycle spent in PRESSED after DB_PRESS.
REQ-016 The btn_pulse latency SHALL be fixed: btn_pulse is 1 in the cycle after clock edge DEBOUNCE_CYCLES+2, counting the edge that first samples btn_raw=1 as edge 0, for stable input.
REQ-017 PRESSED SHALL go to DB_RELEASE when the synchronized input is 0, with the counter cleared.
REQ-018 DB_RELEASE SHALL return to PRESSED on any 1, without generating a pulse.
REQ-019 DB_RELEASE SHALL go to IDLE when the counter reaches DEBOUNCE_CYCLES-1 with the input at 0.
REQ-020 btn_level SHALL be 1 exactly while the channel is in PRESSED or DB_RELEASE.
REQ-021 Channels SHALL be fully independent, and simultaneous presses SHALL produce simultaneous pulses with no priority or masking.
REQ-022 Bounce shorter than DEBOUNCE_CYCLES on either edge SHALL generate no extra pulse.
REQ-023 Counter width SHALL be $clog2 of the largest count parameter, and counters SHALL saturate, never wrap.

Reset
REQ-024 On reset asserted, every channel SHALL enter IDLE and all synchronizer flops, counters, btn_pulse and btn_level SHALL clear to 0 asynchronously.
REQ-025 Reset asserted mid-debounce or while held SHALL discard that press, and a button still held at reset release SHALL pulse once after the full debounce.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN, when defined, SHALL make PRESSED count held cycles and emit a one-cycle btn_pulse after REPEAT_DELAY cycles and then every REPEAT_RATE cycles while held.
REQ-027 With BTN_AUTOREPEAT_EN defined, the hold counter SHALL clear on entering PRESSED, including re-entry from DB_RELEASE, and SHALL freeze in DB_RELEASE.
REQ-028 Without BTN_AUTOREPEAT_EN, exactly one pulse SHALL occur per accepted press, and no hold counter or repeat logic SHALL be synthesized.

Structure
REQ-029 The shared package SHALL hold the four-state FSM enum typedef and the default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE.
REQ-030 One sub-module, btn_debounce_ch (single channel: synchronizer, FSM, counters), SHALL be instantiated NUM_BTN times via generate.

Verification
REQ-031 Bench parameters SHALL be NUM_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, and the bench SHALL cover at least the scenarios below.
REQ-032 Scenario: btn_raw[0] steps to 1 at edge 0 and is held -> btn_pulse[0] is 1 only in the cycle after edge 6, and btn_level[0] rises at the same edge.
REQ-033 Scenario: btn_raw[1] toggles 1,0,1,0 on single cycles and then settles at 1 -> exactly one btn_pulse[1], six cycles after settling.
REQ-034 Scenario: held press released with a 2-cycle bounce back to 1 -> btn_level stays 1, and no second pulse occurs.
REQ-035 Scenario: all three buttons pressed on the same edge -> btn_pulse equals 3'b111 for one cycle.
REQ-036 Scenario: reset asserted 2 cycles into DB_PRESS while held -> outputs are 0 immediately, and after reset release one pulse follows a full debounce.
REQ-037 Scenario: BTN_AUTOREPEAT_EN defined, button held for 30 cycles -> pulses at entry, entry+10, entry+13, entry+16, and so on; without the macro, only the entry pulse.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_RATE     = 5000000;

    // One counter width serves both the debounce and the hold counters.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and press strobe.
// BTN_AUTOREPEAT_EN adds a hold counter that re-strobes while the button is held.
module btn_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic pulse_o,
    output logic level_o
);
    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             press_acc;
    logic             rpt_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_acc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d = ST_DB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DB_PRESS: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_PRESSED;
                    press_acc = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_DB_RELEASE: begin
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_RATE - 1);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rpt_q, rpt_d;

    // rpt_q selects the inter-repeat period once the first repeat has fired.
    always_comb begin
        hold_d   = hold_q;
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if ((state_d == ST_PRESSED) && (state_q != ST_PRESSED)) begin
            hold_d = '0;
            rpt_d  = 1'b0;
        end else if ((state_q == ST_PRESSED) && sync2_q) begin
            if (hold_q == (rpt_q ? RPT_NEXT : RPT_FIRST)) begin
                rpt_fire = 1'b1;
                hold_d   = '0;
                rpt_d    = 1'b1;
            end else begin
                hold_d = sat_inc(hold_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            rpt_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rpt_q  <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign pulse_d = press_acc | rpt_fire;
    assign level_d = (state_d == ST_PRESSED) || (state_d == ST_DB_RELEASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button front end: NUM_BTN independent channels with press strobes and held levels.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat strobes.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_level
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn_raw_i(btn_raw[g]),
            .pulse_o  (btn_pulse[g]),
            .level_o  (btn_level[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: run-length reference model plus directed scenario checks.
module tb_button_conditioner;
    localparam int NB = 3;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_pulse;
    logic [NB-1:0] btn_level;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_n;
        logic [NB-1:0] pulse;
        logic [NB-1:0] level;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Observed-output statistics kept by the monitor.
    int pulse_cnt[NB];
    int last_pulse_edge[NB];
    int level_rise_edge[NB];
    int fall_cnt[NB];
    int all_cnt = 0;
    logic [NB-1:0] lvl_prev = '0;

    // Reference model: synchronizer as a two-deep delay line, debounce as a run length.
    logic [NB-1:0] raw_hist[$];
    logic [NB-1:0] m_level = '0;
    int run[NB];
    int held[NB];
    int next_rep[NB];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_edge(input logic rst_now);
        exp_t e;
        logic [NB-1:0] s;
        e.edge_n = edge_n;
        e.pulse  = '0;
        if (rst_now) begin
            raw_hist.delete();
            raw_hist.push_back('0);
            raw_hist.push_back('0);
            m_level = '0;
            for (int c = 0; c < NB; c++) begin
                run[c] = 0;
                held[c] = 0;
                next_rep[c] = RD;
            end
        end else begin
            raw_hist.push_back(btn_raw);
            s = raw_hist.pop_front();
            for (int c = 0; c < NB; c++) begin
                if (s[c] != m_level[c]) begin
                    run[c]++;
                    if (run[c] == DB + 1) begin
                        m_level[c] = ~m_level[c];
                        run[c] = 0;
                        if (m_level[c]) begin
                            e.pulse[c] = 1'b1;
                            held[c] = 0;
                            next_rep[c] = RD;
                        end
                    end
                end else begin
                    if (m_level[c]) begin
                        if (run[c] != 0) begin
                            held[c] = 0;
                            next_rep[c] = RD;
                        end else begin
                            held[c]++;
`ifdef BTN_AUTOREPEAT_EN
                            if (held[c] == next_rep[c]) begin
                                e.pulse[c] = 1'b1;
                                next_rep[c] += RR;
                            end
`endif
                        end
                    end
                    run[c] = 0;
                end
            end
        end
        e.level = m_level;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [NB-1:0] raw, input logic rst);
        @(negedge clk);
        btn_raw = raw;
        reset   = rst;
        @(posedge clk);
        edge_n++;
        model_edge(reset);
    endtask

    task automatic reset_now(input logic [NB-1:0] raw, input string tag);
        @(negedge clk);
        btn_raw = raw;
        reset   = 1'b1;
        #1;
        chk({tag, "_async_pulse"}, int'(btn_pulse), 0);
        chk({tag, "_async_level"}, int'(btn_level), 0);
        @(posedge clk);
        edge_n++;
        model_edge(1'b1);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (btn_pulse !== e.pulse || btn_level !== e.level) begin
                    failures++;
                    $display("FAIL cycle edge=%0d pulse got %b want %b level got %b want %b",
                             e.edge_n, btn_pulse, e.pulse, btn_level, e.level);
                end
                for (int c = 0; c < NB; c++) begin
                    if (btn_pulse[c] === 1'b1) begin
                        pulse_cnt[c]++;
                        last_pulse_edge[c] = e.edge_n;
                    end
                    if (btn_level[c] === 1'b1 && !lvl_prev[c]) level_rise_edge[c] = e.edge_n;
                    if (btn_level[c] === 1'b0 && lvl_prev[c]) fall_cnt[c]++;
                end
                if (btn_pulse === {NB{1'b1}}) all_cnt++;
                lvl_prev = btn_level;
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t0, ts, p0, p1, p2, f0, a0, rep_exp;
        logic [NB-1:0] rnd_val;
        int rnd_len[NB];

        repeat (3) step('0, 1'b1);
        repeat (4) step('0, 1'b0);

        // Single stable press on channel 0.
        p0 = pulse_cnt[0];
        step(3'b001, 1'b0);
        t0 = edge_n;
        repeat (11) step(3'b001, 1'b0);
        #3;
        chk("s1_pulse_count", pulse_cnt[0] - p0, 1);
        chk("s1_pulse_edge", last_pulse_edge[0] - t0, DB + 2);
        chk("s1_level_edge", level_rise_edge[0] - t0, DB + 2);
        repeat (DB + 6) step('0, 1'b0);
        #3;
        chk("s1_level_released", int'(btn_level[0]), 0);

        // Single-cycle bounce on channel 1 before settling.
        p1 = pulse_cnt[1];
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        step(3'b010, 1'b0);
        step(3'b000, 1'b0);
        step(3'b010, 1'b0);
        ts = edge_n;
        repeat (10) step(3'b010, 1'b0);
        #3;
        chk("s2_pulse_count", pulse_cnt[1] - p1, 1);
        chk("s2_pulse_edge", last_pulse_edge[1] - ts, DB + 2);
        repeat (DB + 6) step('0, 1'b0);

        // Release bounce on channel 2 must not drop the level or re-strobe.
        p2 = pulse_cnt[2];
        repeat (10) step(3'b100, 1'b0);
        #3;
        f0 = fall_cnt[2];
        repeat (2) step(3'b000, 1'b0);
        repeat (8) step(3'b100, 1'b0);
        #3;
        chk("s3_pulse_count", pulse_cnt[2] - p2, 1);
        chk("s3_level_held", fall_cnt[2] - f0, 0);
        chk("s3_level_now", int'(btn_level[2]), 1);
        repeat (DB + 6) step('0, 1'b0);

        // Simultaneous press on all channels.
        a0 = all_cnt;
        repeat (10) step(3'b111, 1'b0);
        #3;
        chk("s4_all_pulse", all_cnt - a0, 1);
        repeat (DB + 6) step('0, 1'b0);

        // Reset during press debounce, button still held across reset.
        p0 = pulse_cnt[0];
        step(3'b001, 1'b0);
        repeat (3) step(3'b001, 1'b0);
        reset_now(3'b001, "s5_reset");
        chk("s5_no_pulse_before_reset", pulse_cnt[0] - p0, 0);
        step(3'b001, 1'b1);
        step(3'b001, 1'b0);
        t0 = edge_n;
        repeat (11) step(3'b001, 1'b0);
        #3;
        chk("s5_pulse_count", pulse_cnt[0] - p0, 1);
        chk("s5_pulse_edge", last_pulse_edge[0] - t0, DB + 2);
        repeat (DB + 6) step('0, 1'b0);

        // Long hold: entry strobe, plus repeats when auto-repeat is built in.
`ifdef BTN_AUTOREPEAT_EN
        rep_exp = 9;
`else
        rep_exp = 1;
`endif
        p0 = pulse_cnt[0];
        step(3'b001, 1'b0);
        t0 = edge_n;
        repeat (39) step(3'b001, 1'b0);
        #3;
        chk("s6_hold_pulse_count", pulse_cnt[0] - p0, rep_exp);
        chk("s6_first_pulse_edge_ok", int'(last_pulse_edge[0] - t0 >= DB + 2), 1);
        reset_now(3'b001, "s6_reset_held");
        step(3'b001, 1'b1);
        p0 = pulse_cnt[0];
        step(3'b001, 1'b0);
        t0 = edge_n;
        repeat (9) step(3'b001, 1'b0);
        #3;
        chk("s6_post_reset_pulse", pulse_cnt[0] - p0, 1);
        chk("s6_post_reset_edge", last_pulse_edge[0] - t0, DB + 2);
        repeat (DB + 6) step('0, 1'b0);

        // Random bouncing on all channels, scored by the model.
        rnd_val = '0;
        for (int c = 0; c < NB; c++) rnd_len[c] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (rnd_len[c] == 0) begin
                    rnd_val[c] = 1'($urandom_range(0, 1));
                    rnd_len[c] = int'($urandom_range(1, 9));
                end
                rnd_len[c]--;
            end
            step(rnd_val, 1'b0);
        end
        repeat (DB + 6) step('0, 1'b0);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
